decode: RTL
===========

# decode

Instruction decode stage for the RV64I in-order pipeline, directly downstream of the fetch stage's IF/ID register. Consumes the registered `inst`/`pc`, drives register-file read addresses combinationally, and decodes opcode, ALU operation, immediate and control flags. Detects load-use hazards and holds the result in an ID/EX pipeline register for the execute stage.

## Interface
Parameters:
- `NOP_INST`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  global stall; hold ID/EX register.
- `clear`  in  1  flush; load bubble into ID/EX.
- `inst`  in  32  instruction from IF/ID, always 32-bit form.
- `pc`  in  64  PC of `inst`.
- `ex_load`  in  1  instruction currently in EX is a load.
- `ex_rd`  in  5  destination register of instruction in EX.
- `rs1`, `rs2`  out  5  combinational register-file read addresses.
- `load_stall`  out  1  combinational load-use hazard; upstream ORs it into fetch `stall`.
- `id_valid`  out  1  ID/EX holds a real instruction.
- `id_pc`  out  64  registered PC.
- `id_rd`  out  5  destination; 0 if no write.
- `id_rs1`, `id_rs2`  out  5  registered source addresses for forwarding.
- `id_imm`  out  64  sign-extended immediate.
- `id_alu_op`  out  4  ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- `id_ctl`  out  10  {word, load, store, branch, jal, jalr, lui, auipc, system, illegal}.
- `id_funct3`  out  3  raw funct3 for load/store width and branch condition.

## Operation
- Formats: R, I, S, B, U, J; immediates sign-extended from bit 31 to 64 bits; B/J immediates have bit 0 = 0.
- Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, MISC-MEM (treated as NOP), SYSTEM.
- Unknown opcode or invalid funct3/funct7 combination: `illegal`=1, `id_rd`=0, `id_valid`=1 (trap raised later in the pipeline).
- `word`=1 for OP-32/OP-IMM-32; RV64 shift immediates use 6-bit shamt, 32-bit variants 5-bit (shamt[5]=1 in a `*W` variant is illegal).
- Store/branch: `id_rd`=0. rs1/rs2 reported only when the format uses them, else 0.
- `inst`==`NOP_INST` decodes to `id_valid`=0.
- Hazard: `load_stall` = `ex_load` & `ex_rd`!=0 & (`ex_rd`==used rs1 | `ex_rd`==used rs2).

## Timing
- Latency: 1 cycle from `inst` to ID/EX outputs.
- Reset: `id_valid`=0, `id_pc`=0, `id_rd`/`id_rs1`/`id_rs2`=0, `id_imm`=0, `id_alu_op`=ADD, `id_ctl`=0, `id_funct3`=0.
- Update priority per edge: `clear` > `stall` > `load_stall` > normal load.
- `clear`: bubble (`id_valid`=0, `id_rd`=0, `id_ctl`=0) even when `stall` is asserted.
- `stall` (no `clear`): all ID/EX outputs held.
- `load_stall` (no `stall`/`clear`): bubble into ID/EX; the instruction held in IF/ID re-decodes next cycle. Exactly one bubble per load-use.
- Reset asserted mid-operation: outputs go to reset values asynchronously; first decode occurs on the first edge after release.

## Structure
- Opcode, funct3/funct7 constants and ALU-op encoding belong in `isa.vh`; `id_ctl` bit positions are `define`d there as well.
- One sub-module: `imm_gen`, purely combinational (inst → 64-bit immediate, selected by format).
- Hazard logic and the ID/EX register live in `decode` itself.

## Test plan
- `inst`=0x0050_0093 (`addi x1,x0,5`) → next cycle: `id_rd`=1, `id_imm`=5, `id_alu_op`=ADD, `id_valid`=1.
- `inst`=0xFE00_0EE3 (`beq x0,x0,-4`) → `id_imm`=0xFFFF_FFFF_FFFF_FFFC, `branch`=1, `id_rd`=0.
- EX holds `lw x2,0(x1)` (`ex_load`=1, `ex_rd`=2) while ID holds 0x0021_01B3 (`add x3,x2,x2`) → `load_stall`=1 for 1 cycle, bubble in ID/EX, then the add issues with `id_rd`=3.
- `clear`=1 together with `stall`=1 → next cycle `id_valid`=0, `id_ctl`=0.
- `inst`=0xFFFF_FFFF → `illegal`=1, `id_rd`=0; `inst`=NOP → `id_valid`=0.
- Assert `rst_n`=0 mid-stream → all outputs at reset values immediately; release → normal decode resumes.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared RV64I decode definitions.
//   Opcode / funct3 / funct7 constants, ALU-op encoding, immediate format
//   selector, id_ctl bit positions and the ID/EX register layout.
package decode_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 values that need special handling
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_SYS_BAD = 3'b100;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // FMT_SH: zero-extended 6-bit shift amount, so execute never sees the
    // funct7 bits that SRAI carries in the I-immediate field.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_e;

    // id_ctl bit positions: {word, load, store, branch, jal, jalr, lui, auipc, system, illegal}
    localparam int CTL_W       = 10;
    localparam int CTL_WORD    = 9;
    localparam int CTL_LOAD    = 8;
    localparam int CTL_STORE   = 7;
    localparam int CTL_BRANCH  = 6;
    localparam int CTL_JAL     = 5;
    localparam int CTL_JALR    = 4;
    localparam int CTL_LUI     = 3;
    localparam int CTL_AUIPC   = 2;
    localparam int CTL_SYSTEM  = 1;
    localparam int CTL_ILLEGAL = 0;

    typedef struct packed {
        logic             valid;
        logic [63:0]      pc;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [63:0]      imm;
        alu_op_e          alu_op;
        logic [CTL_W-1:0] ctl;
        logic [2:0]       funct3;
    } id_ex_t;

    // Reset value doubles as the bubble.
    localparam id_ex_t ID_EX_RESET = '{
        valid:  1'b0,
        pc:     64'd0,
        rd:     5'd0,
        rs1:    5'd0,
        rs2:    5'd0,
        imm:    64'd0,
        alu_op: ALU_ADD,
        ctl:    10'd0,
        funct3: 3'd0
    };

    // Register/immediate ALU op from funct3; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: combinational immediate generator.
//   inst : 32-bit instruction
//   fmt  : immediate format selected by the decoder
//   imm  : 64-bit immediate, sign-extended from inst[31] (shamt zero-extended)
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_fmt_e    fmt,
    output logic [63:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{52{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_SH:  imm = {58'b0, inst[25:20]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// decode: RV64I instruction decode stage with ID/EX pipeline register.
//   clk, rst_n        : clock, async active-low reset
//   stall, clear      : hold / flush the ID/EX register (clear wins)
//   inst, pc          : instruction and its PC from IF/ID
//   ex_load, ex_rd    : load-in-EX info for load-use hazard detection
//   rs1, rs2          : combinational register-file read addresses
//   load_stall        : combinational load-use hazard
//   id_*              : registered ID/EX outputs for the execute stage
module decode
    import decode_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        clear,
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        load_stall,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [63:0] id_imm,
    output logic [3:0]  id_alu_op,
    output logic [9:0]  id_ctl,
    output logic [2:0]  id_funct3
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opcode = inst[6:0];
    assign rd_f   = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];
    assign f7     = inst[31:25];

    imm_fmt_e         fmt;
    alu_op_e          alu;
    logic [CTL_W-1:0] ctl;
    logic             use_rd, use_rs1, use_rs2, illegal;
    logic [63:0]      imm;

    always_comb begin
        fmt     = FMT_NONE;
        alu     = ALU_ADD;
        ctl     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;

        case (opcode)
            OPC_LUI: begin
                fmt = FMT_U; use_rd = 1'b1; ctl[CTL_LUI] = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = FMT_U; use_rd = 1'b1; ctl[CTL_AUIPC] = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J; use_rd = 1'b1; ctl[CTL_JAL] = 1'b1;
            end
            OPC_JALR: begin
                fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; ctl[CTL_JALR] = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; ctl[CTL_BRANCH] = 1'b1;
                // eq/ne compare by subtraction, signed/unsigned by set-less-than
                case (f3[2:1])
                    2'b00:   alu = ALU_SUB;
                    2'b10:   alu = ALU_SLT;
                    2'b11:   alu = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; ctl[CTL_LOAD] = 1'b1;
                illegal = (f3 == 3'b111);
            end
            OPC_STORE: begin
                fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; ctl[CTL_STORE] = 1'b1;
                illegal = f3[2];
            end
            OPC_OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                if (f3 == F3_SLL) begin
                    fmt = FMT_SH; alu = ALU_SLL;
                    illegal = (inst[31:26] != 6'b000000);
                end else if (f3 == F3_SRL_SRA) begin
                    fmt = FMT_SH;
                    if (inst[31:26] == 6'b000000)      alu = ALU_SRL;
                    else if (inst[31:26] == 6'b010000) alu = ALU_SRA;
                    else                               illegal = 1'b1;
                end else begin
                    fmt = FMT_I; alu = alu_from_f3(f3, 1'b0);
                end
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == F7_BASE)
                    alu = alu_from_f3(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))
                    alu = alu_from_f3(f3, 1'b1);
                else
                    illegal = 1'b1;
            end
            OPC_OP_IMM_32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; ctl[CTL_WORD] = 1'b1;
                // f7 covers shamt[5], so a set bit 25 lands in the illegal branch
                if (f3 == F3_ADD_SUB) begin
                    fmt = FMT_I; alu = ALU_ADD;
                end else if (f3 == F3_SLL && f7 == F7_BASE) begin
                    fmt = FMT_SH; alu = ALU_SLL;
                end else if (f3 == F3_SRL_SRA && f7 == F7_BASE) begin
                    fmt = FMT_SH; alu = ALU_SRL;
                end else if (f3 == F3_SRL_SRA && f7 == F7_ALT) begin
                    fmt = FMT_SH; alu = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; ctl[CTL_WORD] = 1'b1;
                if (f7 == F7_BASE && (f3 == F3_ADD_SUB || f3 == F3_SLL || f3 == F3_SRL_SRA))
                    alu = alu_from_f3(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))
                    alu = alu_from_f3(f3, 1'b1);
                else
                    illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE / FENCE.I retire as no-ops in this in-order core
                illegal = (f3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                fmt = FMT_I; ctl[CTL_SYSTEM] = 1'b1;
                if (f3 == F3_SYS_BAD) begin
                    illegal = 1'b1;
                end else if (f3 != 3'b000) begin
                    use_rd  = 1'b1;
                    use_rs1 = ~f3[2];   // CSR*I forms carry a uimm in the rs1 field
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            fmt     = FMT_NONE;
            alu     = ALU_ADD;
            ctl     = '0;
            ctl[CTL_ILLEGAL] = 1'b1;
            use_rd  = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    imm_gen u_imm_gen (
        .inst (inst),
        .fmt  (fmt),
        .imm  (imm)
    );

    assign rs1 = use_rs1 ? rs1_f : 5'd0;
    assign rs2 = use_rs2 ? rs2_f : 5'd0;

    // Unused sources read as x0, so ex_rd != 0 alone excludes them.
    assign load_stall = ex_load && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));

    id_ex_t id_ex_d, id_ex_q;

    always_comb begin
        id_ex_d = id_ex_q;
        if (clear) begin
            id_ex_d = ID_EX_RESET;
        end else if (!stall) begin
            if (load_stall) begin
                id_ex_d = ID_EX_RESET;
            end else begin
                id_ex_d.valid  = (inst != NOP_INST);
                id_ex_d.pc     = pc;
                id_ex_d.rd     = use_rd ? rd_f : 5'd0;
                id_ex_d.rs1    = rs1;
                id_ex_d.rs2    = rs2;
                id_ex_d.imm    = imm;
                id_ex_d.alu_op = alu;
                id_ex_d.ctl    = ctl;
                id_ex_d.funct3 = f3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) id_ex_q <= ID_EX_RESET;
        else        id_ex_q <= id_ex_d;
    end

    assign id_valid  = id_ex_q.valid;
    assign id_pc     = id_ex_q.pc;
    assign id_rd     = id_ex_q.rd;
    assign id_rs1    = id_ex_q.rs1;
    assign id_rs2    = id_ex_q.rs2;
    assign id_imm    = id_ex_q.imm;
    assign id_alu_op = id_ex_q.alu_op;
    assign id_ctl    = id_ex_q.ctl;
    assign id_funct3 = id_ex_q.funct3;

endmodule
